// File: rtl/up_down_sequence_monitor_pkg.sv
// Shared encodings for the up/down sequence monitor: FSM states, step classes
// and the error counter ceiling.
package up_down_sequence_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACQ  = 2'd1,
    ST_LOCK = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    STEP_HOLD    = 2'd0,
    STEP_UP      = 2'd1,
    STEP_DOWN    = 2'd2,
    STEP_ILLEGAL = 2'd3
  } step_e;

  localparam logic [7:0] ERR_CNT_MAX = 8'd255;

  function automatic logic [7:0] err_cnt_inc(input logic [7:0] cnt);
    return (cnt == ERR_CNT_MAX) ? cnt : cnt + 8'd1;
  endfunction

endpackage

// File: rtl/up_down_sequence_monitor_step_classifier.sv
// Combinational step classifier: modular delta between consecutive samples
// mapped to HOLD / UP / DOWN / ILLEGAL.
module step_classifier
  import up_down_sequence_monitor_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] prev_i,
  input  logic [WIDTH-1:0] q_i,
  output logic [1:0]       class_o
);

  logic [WIDTH-1:0] delta;

  // Modular subtraction makes the wrap cases (max->0, 0->max) fall out as +/-1.
  assign delta = q_i - prev_i;

  always_comb begin
    class_o = STEP_ILLEGAL;
    if (delta == '0) begin
      class_o = STEP_HOLD;
    end else if (delta == WIDTH'(1)) begin
      class_o = STEP_UP;
    end else if (delta == {WIDTH{1'b1}}) begin
      class_o = STEP_DOWN;
    end
  end

endmodule

// File: rtl/up_down_sequence_monitor.sv
// Up/down counter bus monitor: infers direction, locks on a consistent run, counts steps
// and flags illegal jumps. Optional stall detection enabled by MON_STALL_CHECK_EN.
module up_down_sequence_monitor
  import up_down_sequence_monitor_pkg::*;
#(
  parameter int WIDTH       = 3,
  parameter int LOCK_CNT    = 2,
  parameter int STALL_LIMIT = 4
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             sample_en_i,
  input  logic [WIDTH-1:0] q_in_i,
  output logic             dir_o,
  output logic             locked_o,
  output logic             err_o,
  output logic [7:0]       err_cnt_o,
  output logic [15:0]      step_cnt_o,
  output logic             stall_o
);

  localparam int              RUN_W   = $clog2(LOCK_CNT + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(LOCK_CNT);

  if (LOCK_CNT < 1 || STALL_LIMIT < 1) begin : g_param_check
    $error("up_down_sequence_monitor: LOCK_CNT and STALL_LIMIT must be >= 1");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             dir_q, dir_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic [15:0]      step_cnt_q, step_cnt_d;

  logic [1:0] cls_raw;
  step_e      cls;
  logic       step_dir;

  step_classifier #(.WIDTH(WIDTH)) u_step_classifier (
    .prev_i  (prev_q),
    .q_i     (q_in_i),
    .class_o (cls_raw)
  );

  assign cls      = step_e'(cls_raw);
  assign step_dir = (cls == STEP_DOWN);

  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    run_d      = run_q;
    dir_d      = dir_q;
    locked_d   = locked_q;
    err_d      = 1'b0;
    err_cnt_d  = err_cnt_q;
    step_cnt_d = step_cnt_q;

    if (sample_en_i) begin
      prev_d = q_in_i;
      case (state_q)
        ST_IDLE: begin
          state_d = ST_ACQ;
          run_d   = '0;
        end
        ST_ACQ, ST_LOCK: begin
          case (cls)
            STEP_ILLEGAL: begin
              err_d     = 1'b1;
              err_cnt_d = err_cnt_inc(err_cnt_q);
              state_d   = ST_ACQ;
              run_d     = '0;
              locked_d  = 1'b0;
            end
            STEP_UP, STEP_DOWN: begin
              step_cnt_d = step_cnt_q + 16'd1;
              if (state_q == ST_LOCK) begin
                // A reversal out of lock is a legal counter behaviour, not an error.
                if (step_dir != dir_q) begin
                  state_d  = ST_ACQ;
                  dir_d    = step_dir;
                  run_d    = RUN_W'(1);
                  locked_d = 1'b0;
                end
              end else begin
                if (run_q == '0 || step_dir == dir_q) begin
                  run_d = (run_q == RUN_MAX) ? RUN_MAX : run_q + RUN_W'(1);
                end else begin
                  run_d = RUN_W'(1);
                end
                dir_d = step_dir;
                if (run_d == RUN_MAX) begin
                  state_d  = ST_LOCK;
                  locked_d = 1'b1;
                end
              end
            end
            default: ;
          endcase
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!clr_i) begin
      state_q    <= ST_IDLE;
      prev_q     <= '0;
      run_q      <= '0;
      dir_q      <= 1'b0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
      step_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      run_q      <= run_d;
      dir_q      <= dir_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
      step_cnt_q <= step_cnt_d;
    end
  end

  assign dir_o      = dir_q;
  assign locked_o   = locked_q;
  assign err_o      = err_q;
  assign err_cnt_o  = err_cnt_q;
  assign step_cnt_o = step_cnt_q;

`ifdef MON_STALL_CHECK_EN
  localparam int               HOLD_W   = $clog2(STALL_LIMIT + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(STALL_LIMIT);

  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              stall_q, stall_d;

  // The first sample after IDLE has no predecessor, so it never counts as a hold.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    stall_d    = stall_q;
    if (sample_en_i) begin
      if (state_q != ST_IDLE && cls == STEP_HOLD) begin
        hold_cnt_d = (hold_cnt_q == HOLD_MAX) ? HOLD_MAX : hold_cnt_q + HOLD_W'(1);
      end else begin
        hold_cnt_d = '0;
      end
      stall_d = (hold_cnt_d == HOLD_MAX);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!clr_i) begin
      hold_cnt_q <= '0;
      stall_q    <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      stall_q    <= stall_d;
    end
  end

  assign stall_o = stall_q;
`else
  assign stall_o = 1'b0;
`endif

endmodule
